instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly upstream of instruction_mem. Owns the program counter (PC) and
//  drives instruction_address. Captures the combinational instruction_data into an
//  output instruction register. Hands each instruction to decode over a valid/ready
//  handshake; supports stall, PC redirect (branch/jump) and halt-on-opcode.
// PARAMETERS
//  ADDR_WIDTH   8      width of PC / instruction_address
//  DATA_WIDTH   8      instruction width
//  MEM_DEPTH    64     number of instruction words; PC wraps at MEM_DEPTH-1
//  RESET_PC     0      PC value after reset
//  HALT_OPCODE  8'hFF  instruction value that stops fetching
// PORTS
//  clk                 in   1           single clock, rising edge
//  rst_n               in   1           synchronous reset, active-low
//  instruction_address out  ADDR_WIDTH  to instruction_mem; equals PC register
//  instruction_data    in   DATA_WIDTH  from instruction_mem, valid same cycle
//  fetch_valid         out  1           fetch_instruction/fetch_pc hold a valid instr
//  fetch_ready         in   1           decode accepts when fetch_valid && fetch_ready
//  fetch_instruction   out  DATA_WIDTH  captured instruction
//  fetch_pc            out  ADDR_WIDTH  address the captured instruction came from
//  redirect_valid      in   1           load redirect_target into PC, flush output reg
//  redirect_target     in   ADDR_WIDTH  new PC
//  halted              out  1           high while in HALT state
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge, any state): pc=RESET_PC, fetch_valid=0,
//    fetch_instruction=0, fetch_pc=0, halted=0, state=RUN. Overrides all other inputs.
//  - instruction_address = pc (register output, no combinational path from inputs).
//  - pc_next = (pc == MEM_DEPTH-1) ? 0 : pc+1.
//  - States: RUN, HALT. halted = (state==HALT).
//  - load = (state==RUN) && (!fetch_valid || fetch_ready) && !redirect_valid.
//  - On load: fetch_instruction<=instruction_data, fetch_pc<=pc, fetch_valid<=1;
//    if instruction_data==HALT_OPCODE, then state<=HALT and pc unchanged;
//    else pc<=pc_next.
//  - RUN, no load, no redirect (stall): pc and output registers hold;
//    fetch_valid/instruction/pc stay stable while fetch_valid && !fetch_ready.
//  - Accept without load is possible only in HALT: there, fetch_valid<=0 on accept.
//    No further captures occur in HALT.
//  - Redirect (priority over load/halt): pc <= (redirect_target >= MEM_DEPTH) ? 0 :
//    redirect_target. fetch_valid<=0, state<=RUN. A held instruction is discarded
//    unless fetch_ready was high that same cycle, in which case it counts as accepted.
//  - Latency: first capture on the first edge with rst_n=1; fetch_valid high after it.
//    After redirect: edge 1 sets pc, edge 2 presents mem[target].
//    Throughput: 1 instr/cycle with fetch_ready held high.
//  - fetch_pc always lags instruction_address by one address when streaming.
// TESTING
//  1 Stream: mem[i]=8'h10+i, fetch_ready=1 -> fetch_pc 0,1,2.. with instr 10,11,12..
//    one per cycle; instruction_address = fetch_pc+1.
//  2 Stall: drop fetch_ready for 3 cycles while fetch_pc=4 -> fetch_pc=4, instr=14,
//    instruction_address=5 all held; raise ready -> 4 accepted, 5 next cycle.
//  3 Wrap: stream to fetch_pc=63 -> next fetch_pc=0, instruction=mem[0].
//  4 Redirect: redirect_target=8'h20 while valid && !ready -> fetch_valid=0 and
//    instruction_address=8'h20 next edge; fetch_pc=8'h20 one edge later.
//    redirect_target=8'h50 -> pc=0.
//  5 Halt: mem[3]=8'hFF -> 0..3 delivered, halted=1 after capturing 3,
//    instruction_address stays 3; ready=1 -> fetch_valid falls, no more fetches;
//    redirect to 0 -> halted=0, streaming restarts at 0.
//  6 Reset mid-stall: rst_n=0 for one edge with valid && !ready -> all outputs at
//    reset values; after release, fetch_pc=RESET_PC delivered first.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction_mem and registers each fetched
// instruction toward decode over a valid/ready handshake. It supports stalls,
// PC redirects and halting on a dedicated opcode.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 64,
    parameter int unsigned RESET_PC   = 0,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = DATA_WIDTH'(8'hFF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0] instruction_data,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] fetch_instruction,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC  = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(RESET_PC);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   fpc_q, fpc_d;
    logic [ADDR_WIDTH-1:0]   pc_next;
    logic                    load;

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= START_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            fpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
        end
    end

    // Next-state: redirect beats capture; capture only in RUN when the output slot frees up
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        fpc_d   = fpc_q;

        pc_next = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_WIDTH'(1);
        load    = (state_q == RUN) && (!valid_q || fetch_ready) && !redirect_valid;

        if (redirect_valid) begin
            // Out-of-range targets fall back to address zero
            pc_d    = (redirect_target > LAST_PC) ? '0 : redirect_target;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (load) begin
            instr_d = instruction_data;
            fpc_d   = pc_q;
            valid_d = 1'b1;
            if (instruction_data == HALT_OPCODE) begin
                state_d = HALT;
            end else begin
                pc_d = pc_next;
            end
        end else if ((state_q == HALT) && valid_q && fetch_ready) begin
            // Halt instruction drained by decode; nothing more is captured
            valid_d = 1'b0;
        end
    end

    assign instruction_address = pc_q;
    assign fetch_valid         = valid_q;
    assign fetch_instruction   = instr_q;
    assign fetch_pc            = fpc_q;
    assign halted              = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instruction_address;
    logic [7:0] instruction_data;
    logic       fetch_valid;
    logic       fetch_ready;
    logic [7:0] fetch_instruction;
    logic [7:0] fetch_pc;
    logic       redirect_valid;
    logic [7:0] redirect_target;
    logic       halted;

    logic [7:0] mem [0:63];
    int n_cmp  = 0;
    int n_fail = 0;

    // Observed/expected vectors: {valid, halted, fetch_pc, instr, address}
    logic [25:0] got, exp;

    always #5 clk = ~clk;

    assign instruction_data = (instruction_address < 8'd64) ? mem[instruction_address[5:0]] : 8'h00;

    instruction_fetch dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_instruction   (fetch_instruction),
        .fetch_pc            (fetch_pc),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .halted              (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 8'h00;
        step(); step();
        got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
        exp = {1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL reset: got %h expected %h", got, exp);
            n_fail++;
        end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
            exp = {1'b1, 1'b0, 8'(i), 8'(8'h10 + i), 8'(i + 1)};
            n_cmp++;
            if (got !== exp) begin
                $display("FAIL stream[%0d]: got %h expected %h", i, got, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
            exp = {1'b1, 1'b0, 8'd4, 8'h14, 8'd5};
            n_cmp++;
            if (got !== exp) begin
                $display("FAIL stall[%0d]: got %h expected %h", i, got, exp);
                n_fail++;
            end
        end
        fetch_ready = 1'b1;
        step();
        got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
        exp = {1'b1, 1'b0, 8'd5, 8'h15, 8'd6};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL stall_release: got %h expected %h", got, exp);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 58; i++) step();
        got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
        exp = {1'b1, 1'b0, 8'd63, 8'h4F, 8'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL wrap_last: got %h expected %h", got, exp);
            n_fail++;
        end
        step();
        got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
        exp = {1'b1, 1'b0, 8'd0, 8'h10, 8'd1};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL wrap_first: got %h expected %h", got, exp);
            n_fail++;
        end
    endtask

    task automatic test_redirect();
        logic [25:0] exp_tab [0:4];
        // Hold, redirect 0x20, fetch 0x20, redirect 0x50 (out of range), fetch 0
        exp_tab[0] = {1'b1, 1'b0, 8'h00, 8'h10, 8'h01};
        exp_tab[1] = {1'b0, 1'b0, 8'h00, 8'h10, 8'h20};
        exp_tab[2] = {1'b1, 1'b0, 8'h20, 8'h30, 8'h21};
        exp_tab[3] = {1'b0, 1'b0, 8'h20, 8'h30, 8'h00};
        exp_tab[4] = {1'b1, 1'b0, 8'h00, 8'h10, 8'h01};
        for (int i = 0; i < 5; i++) begin
            fetch_ready     = (i >= 3);
            redirect_valid  = (i == 1) || (i == 3);
            redirect_target = (i == 1) ? 8'h20 : 8'h50;
            step();
            got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
            n_cmp++;
            if (got !== exp_tab[i]) begin
                $display("FAIL redirect[%0d]: got %h expected %h", i, got, exp_tab[i]);
                n_fail++;
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_halt();
        logic [25:0] exp_tab [0:9];
        logic        rdy_tab [0:9];
        logic        rdr_tab [0:9];
        mem[3] = 8'hFF;
        exp_tab[0] = {1'b0, 1'b0, 8'h00, 8'h10, 8'h00}; rdy_tab[0] = 1'b1; rdr_tab[0] = 1'b1;
        exp_tab[1] = {1'b1, 1'b0, 8'h00, 8'h10, 8'h01}; rdy_tab[1] = 1'b1; rdr_tab[1] = 1'b0;
        exp_tab[2] = {1'b1, 1'b0, 8'h01, 8'h11, 8'h02}; rdy_tab[2] = 1'b1; rdr_tab[2] = 1'b0;
        exp_tab[3] = {1'b1, 1'b0, 8'h02, 8'h12, 8'h03}; rdy_tab[3] = 1'b1; rdr_tab[3] = 1'b0;
        exp_tab[4] = {1'b1, 1'b1, 8'h03, 8'hFF, 8'h03}; rdy_tab[4] = 1'b1; rdr_tab[4] = 1'b0;
        exp_tab[5] = {1'b1, 1'b1, 8'h03, 8'hFF, 8'h03}; rdy_tab[5] = 1'b0; rdr_tab[5] = 1'b0;
        exp_tab[6] = {1'b0, 1'b1, 8'h03, 8'hFF, 8'h03}; rdy_tab[6] = 1'b1; rdr_tab[6] = 1'b0;
        exp_tab[7] = {1'b0, 1'b1, 8'h03, 8'hFF, 8'h03}; rdy_tab[7] = 1'b1; rdr_tab[7] = 1'b0;
        exp_tab[8] = {1'b0, 1'b0, 8'h03, 8'hFF, 8'h00}; rdy_tab[8] = 1'b1; rdr_tab[8] = 1'b1;
        exp_tab[9] = {1'b1, 1'b0, 8'h00, 8'h10, 8'h01}; rdy_tab[9] = 1'b1; rdr_tab[9] = 1'b0;
        redirect_target = 8'h00;
        for (int i = 0; i < 10; i++) begin
            fetch_ready    = rdy_tab[i];
            redirect_valid = rdr_tab[i];
            if (i == 8) mem[3] = 8'h13;
            step();
            got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
            n_cmp++;
            if (got !== exp_tab[i]) begin
                $display("FAIL halt[%0d]: got %h expected %h", i, got, exp_tab[i]);
                n_fail++;
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        fetch_ready = 1'b0;
        step();
        got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
        exp = {1'b1, 1'b0, 8'h00, 8'h10, 8'h01};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL pre_reset_hold: got %h expected %h", got, exp);
            n_fail++;
        end
        rst_n = 1'b0;
        step();
        got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
        exp = {1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL mid_stall_reset: got %h expected %h", got, exp);
            n_fail++;
        end
        rst_n = 1'b1;
        step();
        got = {fetch_valid, halted, fetch_pc, fetch_instruction, instruction_address};
        exp = {1'b1, 1'b0, 8'h00, 8'h10, 8'h01};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL post_reset_first: got %h expected %h", got, exp);
            n_fail++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(8'h10 + i);
        rst_n = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;
        test_reset();
        test_stream();
        test_stall();
        test_wrap();
        test_redirect();
        test_halt();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
